// File: rtl/ext_bus_pkg.sv
// Shared EXT bus definitions: transfer sizes, responder states and address map constants
// for the ext_acc_slave accelerator bridge.
package ext_bus_pkg;

   typedef enum logic [2:0] {
      SZ_BYTE = 3'b000,
      SZ_HALF = 3'b001,
      SZ_WORD = 3'b010
   } hsize_e;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RD_WAIT,
      RD_DONE,
      NOP
   } ext_state_e;

   // Accelerator register window is the first 16 words of the EXT space.
   localparam logic [31:0] ACC_MAP_LIMIT = 32'h0000_0040;
   localparam logic [31:0] ERRCNT_ADDR   = 32'h0000_0040;

endpackage

// File: rtl/ext_be_decode.sv
// Combinational byte-enable decoder for EXT transfers; an all-zero enable marks an illegal
// size/alignment combination.
module ext_be_decode
   import ext_bus_pkg::*;
(
   input  logic [2:0] hsize_i,
   input  logic [1:0] addr_i,
   output logic [3:0] be_o,
   output logic       illegal_o
);

   always_comb begin
      be_o = '0;
      case (hsize_i)
         SZ_BYTE: be_o = 4'b0001 << addr_i;
         SZ_HALF: begin
            case (addr_i)
               2'd0:    be_o = 4'b0011;
               2'd1:    be_o = 4'b0110;
               2'd2:    be_o = 4'b1100;
               default: be_o = '0;
            endcase
         end
         SZ_WORD: be_o = (addr_i == 2'd0) ? 4'b1111 : 4'b0000;
         default: be_o = '0;
      endcase
   end

   assign illegal_o = (be_o == '0);

endmodule

// File: rtl/ext_acc_slave.sv
// EXT bus responder bridging AHB-lite-style transfers onto a 16-word accelerator register port.
// Optional error counter at 0x0040 enabled by defining EXT_ACC_SLAVE_ERRCNT_EN.
module ext_acc_slave
   import ext_bus_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned AWIDTH       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              EXT_HSEL,
   input  logic [AWIDTH-1:0] EXT_HADDR,
   input  logic              EXT_HWRITE,
   input  logic [2:0]        EXT_HSIZE,
   input  logic [31:0]       EXT_HWDATA,
   output logic [31:0]       EXT_HRDATA,
   output logic              EXT_HREADYOUT,
   output logic [3:0]        acc_addr,
   output logic              acc_en,
   output logic              acc_we,
   output logic [3:0]        acc_be,
   output logic [31:0]       acc_din,
   input  logic [31:0]       acc_dout
);

   ext_state_e  state_q;
   logic        hready_q;
   logic        acc_en_q;
   logic        acc_we_q;
   logic [3:0]  acc_addr_q;
   logic [3:0]  acc_be_q;
   logic [2:0]  lat_cnt_q;

   logic [3:0]  be_d;
   logic        illegal_d;
   logic        mapped_d;
   logic        accept_d;
   logic        errcnt_hit_d;
   logic [31:0] aux_rdata_d;

   ext_be_decode u_be_decode (
      .hsize_i   (EXT_HSIZE),
      .addr_i    (EXT_HADDR[1:0]),
      .be_o      (be_d),
      .illegal_o (illegal_d)
   );

   assign accept_d = EXT_HSEL & hready_q;
   assign mapped_d = (32'(EXT_HADDR) < ACC_MAP_LIMIT) & ~illegal_d;

`ifdef EXT_ACC_SLAVE_ERRCNT_EN
   logic [15:0] errcnt_q;
   logic        errrd_q;

   assign errcnt_hit_d = (32'(EXT_HADDR) == ERRCNT_ADDR) & (be_d == 4'b1111);

   // Counter read is served internally as a zero-wait NOP-style data phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         errcnt_q <= '0;
         errrd_q  <= 1'b0;
      end else begin
         errrd_q <= accept_d & errcnt_hit_d & ~EXT_HWRITE;
         if (accept_d && errcnt_hit_d && EXT_HWRITE) begin
            errcnt_q <= '0;
         end else if (accept_d && !mapped_d && !errcnt_hit_d && errcnt_q != '1) begin
            errcnt_q <= errcnt_q + 16'd1;
         end
      end
   end

   assign aux_rdata_d = errrd_q ? {16'h0000, errcnt_q} : '0;
`else
   assign errcnt_hit_d = 1'b0;
   assign aux_rdata_d  = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         hready_q   <= 1'b1;
         acc_en_q   <= 1'b0;
         acc_we_q   <= 1'b0;
         acc_addr_q <= '0;
         acc_be_q   <= '0;
         lat_cnt_q  <= '0;
      end else begin
         case (state_q)
            RD_WAIT: begin
               acc_en_q <= 1'b0;
               acc_we_q <= 1'b0;
               if (lat_cnt_q == '0) begin
                  state_q  <= RD_DONE;
                  hready_q <= 1'b1;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 3'd1;
               end
            end
            default: begin
               acc_en_q <= 1'b0;
               acc_we_q <= 1'b0;
               if (accept_d) begin
                  acc_addr_q <= EXT_HADDR[5:2];
                  acc_be_q   <= be_d;
                  if (mapped_d && EXT_HWRITE) begin
                     state_q  <= WRITE;
                     acc_en_q <= 1'b1;
                     acc_we_q <= 1'b1;
                  end else if (mapped_d) begin
                     state_q   <= RD_WAIT;
                     acc_en_q  <= 1'b1;
                     hready_q  <= 1'b0;
                     lat_cnt_q <= 3'(READ_LATENCY - 1);
                  end else begin
                     state_q <= NOP;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign EXT_HREADYOUT = hready_q;
   assign EXT_HRDATA    = (state_q == RD_DONE) ? acc_dout : aux_rdata_d;
   assign acc_en        = acc_en_q;
   assign acc_we        = acc_we_q;
   assign acc_addr      = acc_addr_q;
   assign acc_be        = acc_be_q;
   assign acc_din       = EXT_HWDATA;

endmodule

// File: tb/tb_ext_acc_slave.sv
// Self-checking bench for ext_acc_slave: directed test-plan steps followed by randomized
// transfer bursts, checked against a transaction-level reference model.
module tb_ext_acc_slave;

   localparam int unsigned RL   = 3;
   localparam int unsigned AW   = 16;
   localparam int          MAXT = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          EXT_HSEL;
   logic [AW-1:0] EXT_HADDR;
   logic          EXT_HWRITE;
   logic [2:0]    EXT_HSIZE;
   logic [31:0]   EXT_HWDATA;
   logic [31:0]   EXT_HRDATA;
   logic          EXT_HREADYOUT;
   logic [3:0]    acc_addr;
   logic          acc_en;
   logic          acc_we;
   logic [3:0]    acc_be;
   logic [31:0]   acc_din;
   logic [31:0]   acc_dout;

   always #5 clk = ~clk;

   ext_acc_slave #(.READ_LATENCY(RL), .AWIDTH(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .EXT_HSEL      (EXT_HSEL),
      .EXT_HADDR     (EXT_HADDR),
      .EXT_HWRITE    (EXT_HWRITE),
      .EXT_HSIZE     (EXT_HSIZE),
      .EXT_HWDATA    (EXT_HWDATA),
      .EXT_HRDATA    (EXT_HRDATA),
      .EXT_HREADYOUT (EXT_HREADYOUT),
      .acc_addr      (acc_addr),
      .acc_en        (acc_en),
      .acc_we        (acc_we),
      .acc_be        (acc_be),
      .acc_din       (acc_din),
      .acc_dout      (acc_dout)
   );

   int tests = 0;
   int fails = 0;

   // Transfer table and per-transfer expectations
   logic [AW-1:0] t_addr  [MAXT];
   logic          t_wr    [MAXT];
   logic [2:0]    t_size  [MAXT];
   logic [31:0]   t_wdata [MAXT];
   int            t_gap   [MAXT];
   int            e_wait  [MAXT];
   int            e_strb  [MAXT];
   logic [31:0]   e_data  [MAXT];
   logic [3:0]    e_be    [MAXT];

   logic [31:0] ref_mem [16];
   int          ref_cnt;
   logic [31:0] mem_seed;
   logic        mem_init = 1'b1;
   bit          junk_en;

   // Accelerator model: byte-masked register file with RL-cycle read pipeline
   logic [31:0] acc_mem [16];
   logic [31:0] pipe_d  [RL];
   logic        pipe_v  [RL];
   logic [31:0] junk_q;

   function automatic logic [31:0] pat(input int i);
      return mem_seed ^ (32'h0103_0507 * 32'(i + 1));
   endfunction

   always @(posedge clk) begin
      junk_q <= $urandom;
      if (mem_init) begin
         for (int i = 0; i < 16; i++) acc_mem[i] <= pat(i);
         for (int i = 0; i < RL; i++) pipe_v[i] <= 1'b0;
      end else begin
         if (acc_en && acc_we)
            for (int b = 0; b < 4; b++)
               if (acc_be[b]) acc_mem[acc_addr][8*b +: 8] <= acc_din[8*b +: 8];
         pipe_v[0] <= acc_en && !acc_we;
         pipe_d[0] <= acc_mem[acc_addr];
         for (int i = 1; i < RL; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   assign acc_dout = pipe_v[RL-1] ? pipe_d[RL-1] : junk_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic add(input int i, input logic [AW-1:0] a, input logic w, input logic [2:0] s,
                      input logic [31:0] d, input int g);
      t_addr[i] = a; t_wr[i] = w; t_size[i] = s; t_wdata[i] = d; t_gap[i] = g;
   endtask

   // Reference model: outcome of a transfer from the address-map and byte-lane rules
   task automatic model_accept(input int k);
      int lo, nb, idx;
      bit legal, mapped, errhit;
      logic [3:0] be;
      lo     = int'(t_addr[k][1:0]);
      idx    = int'(t_addr[k][5:2]);
      legal  = (t_size[k] <= 3'd2) && (lo + (1 << t_size[k]) <= 4);
      nb     = legal ? (1 << t_size[k]) : 0;
      be     = 4'(((1 << nb) - 1) << lo);
      mapped = legal && (t_addr[k] < 16'd64);
`ifdef EXT_ACC_SLAVE_ERRCNT_EN
      errhit = (t_addr[k] == 16'h0040) && (t_size[k] == 3'd2);
`else
      errhit = 1'b0;
`endif
      e_be[k]   = be;
      e_strb[k] = mapped ? 1 : 0;
      e_wait[k] = (mapped && !t_wr[k]) ? int'(RL) : 0;
      e_data[k] = '0;
      if (mapped && t_wr[k]) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[idx][8*b +: 8] = t_wdata[k][8*b +: 8];
      end else if (mapped) begin
         e_data[k] = ref_mem[idx];
      end else if (errhit && t_wr[k]) begin
         ref_cnt = 0;
      end else if (errhit) begin
         e_data[k] = {16'h0000, 16'(ref_cnt)};
      end else if (ref_cnt < 65535) begin
         ref_cnt++;
      end
   endtask

   task automatic drive_xfer(input int k);
      EXT_HSEL = 1'b1; EXT_HADDR = t_addr[k]; EXT_HWRITE = t_wr[k]; EXT_HSIZE = t_size[k];
   endtask

   task automatic drive_idle();
      EXT_HSEL = 1'b0; EXT_HADDR = AW'($urandom); EXT_HWRITE = 1'($urandom); EXT_HSIZE = 3'($urandom);
   endtask

   task automatic drive_junk();
      EXT_HSEL = 1'($urandom); EXT_HADDR = AW'($urandom_range(0, 80)); EXT_HWRITE = 1'($urandom);
      EXT_HSIZE = 3'($urandom_range(0, 2));
   endtask

   // Runs transfers 0..n-1 with pipelined address phases; called at posedge+1
   task automatic run_burst(input int n);
      int k, dp, waits, idle_left, n_strb, guard;
      bit have_dp, rdy, present, acc_now;
      logic s_we; logic [3:0] s_addr, s_be; logic [31:0] s_din;
      k = 0; dp = 0; have_dp = 0; waits = 0; n_strb = 0; guard = 0;
      idle_left = t_gap[0];
      s_we = 1'b0; s_addr = '0; s_be = '0; s_din = '0;
      while (k < n || have_dp) begin
         guard++;
         if (guard > 40 * n + 50) begin
            chk("burst_timeout", 32'(guard), 32'(40 * n + 50));
            break;
         end
         present = (k < n) && (idle_left == 0);
         if (junk_en && !EXT_HREADYOUT) drive_junk();
         else if (present) drive_xfer(k);
         else drive_idle();
         EXT_HWDATA = have_dp ? t_wdata[dp] : $urandom;
         @(negedge clk);
         rdy = EXT_HREADYOUT;
         if (acc_en) begin
            n_strb++; s_we = acc_we; s_addr = acc_addr; s_be = acc_be; s_din = acc_din;
         end
         if (have_dp) begin
            if (!rdy) begin
               waits++;
               chk("hrdata_during_wait", EXT_HRDATA, '0);
            end else begin
               chk("wait_cycles", 32'(waits), 32'(e_wait[dp]));
               chk("hrdata", EXT_HRDATA, e_data[dp]);
               chk("strobe_count", 32'(n_strb), 32'(e_strb[dp]));
               if (e_strb[dp] == 1) begin
                  chk("acc_we", 32'(s_we), 32'(t_wr[dp]));
                  chk("acc_addr", 32'(s_addr), 32'(t_addr[dp][5:2]));
                  chk("acc_be", 32'(s_be), 32'(e_be[dp]));
                  if (t_wr[dp]) chk("acc_din", s_din, t_wdata[dp]);
               end
               have_dp = 0;
            end
         end else begin
            chk("idle_ready", 32'(rdy), 32'd1);
            chk("idle_hrdata", EXT_HRDATA, '0);
            chk("idle_no_strobe", 32'(acc_en), 32'd0);
         end
         acc_now = rdy && EXT_HSEL;
         if (rdy && !present && k < n && idle_left > 0) idle_left--;
         @(posedge clk); #1;
         if (acc_now) begin
            model_accept(k);
            dp = k; have_dp = 1; waits = 0; n_strb = 0;
            k++;
            if (k < n) idle_left = t_gap[k];
         end
      end
      drive_idle();
   endtask

   initial begin
      rst = 1'b1; junk_en = 1'b0; ref_cnt = 0;
      mem_seed = $urandom;
      for (int i = 0; i < 16; i++) ref_mem[i] = pat(i);
      drive_idle(); EXT_HWDATA = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hready", 32'(EXT_HREADYOUT), 32'd1);
      chk("rst_hrdata", EXT_HRDATA, '0);
      chk("rst_acc_en", 32'(acc_en), 32'd0);
      chk("rst_acc_we", 32'(acc_we), 32'd0);
      chk("rst_acc_addr", 32'(acc_addr), 32'd0);
      chk("rst_acc_be", 32'(acc_be), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; mem_init = 1'b0;

      // Word write 0x0008
      add(0, 16'h0008, 1'b1, 3'd2, 32'hDEADBEEF, 0);
      run_burst(1);
      // Word read of 0x000C holding 0x12345678
      add(0, 16'h000C, 1'b1, 3'd2, 32'h12345678, 0);
      add(1, 16'h000C, 1'b0, 3'd2, 32'h0, 1);
      run_burst(2);
      // Byte write 0x0003 then half write 0x0002 back-to-back
      add(0, 16'h0003, 1'b1, 3'd0, $urandom, 0);
      add(1, 16'h0002, 1'b1, 3'd1, $urandom, 0);
      run_burst(2);
      // Read 0x0004 with the write to 0x0004 held during the wait states
      add(0, 16'h0004, 1'b0, 3'd2, 32'h0, 0);
      add(1, 16'h0004, 1'b1, 3'd2, $urandom, 0);
      add(2, 16'h0004, 1'b0, 3'd2, 32'h0, 0);
      run_burst(3);
      // Illegal write, unmapped read, then counter location
      add(0, 16'h0002, 1'b1, 3'd2, $urandom, 0);
      add(1, 16'h0100, 1'b0, 3'd2, 32'h0, 0);
      add(2, 16'h0040, 1'b0, 3'd2, 32'h0, 0);
      add(3, 16'h0040, 1'b1, 3'd2, $urandom, 0);
      add(4, 16'h0040, 1'b0, 3'd2, 32'h0, 0);
      run_burst(5);

      // Reset in the second wait cycle of a read
      EXT_HSEL = 1'b1; EXT_HADDR = 16'h0004; EXT_HWRITE = 1'b0; EXT_HSIZE = 3'd2;
      @(negedge clk);
      chk("rr_accept_ready", 32'(EXT_HREADYOUT), 32'd1);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk("rr_strobe", 32'(acc_en), 32'd1);
      chk("rr_wait1", 32'(EXT_HREADYOUT), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rr_wait2", 32'(EXT_HREADYOUT), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; ref_cnt = 0;
      for (int i = 0; i < int'(RL) + 2; i++) begin
         @(negedge clk);
         chk("rr_after_hready", 32'(EXT_HREADYOUT), 32'd1);
         chk("rr_after_hrdata", EXT_HRDATA, '0);
         chk("rr_after_acc_en", 32'(acc_en), 32'd0);
         @(posedge clk); #1;
      end

      // Reset coinciding with a selected write drops the transfer
      rst = 1'b1;
      EXT_HSEL = 1'b1; EXT_HADDR = 16'h0010; EXT_HWRITE = 1'b1; EXT_HSIZE = 3'd2;
      EXT_HWDATA = $urandom;
      @(posedge clk); #1;
      rst = 1'b0;
      drive_idle();
      @(negedge clk);
      chk("rst_hsel_acc_en", 32'(acc_en), 32'd0);
      chk("rst_hsel_hready", 32'(EXT_HREADYOUT), 32'd1);
      @(posedge clk); #1;
      add(0, 16'h0010, 1'b0, 3'd2, 32'h0, 0);
      run_burst(1);

      // Randomized bursts, with junk address phases during wait states
      junk_en = 1'b1;
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < 12; i++) begin
            int r;
            logic [AW-1:0] a;
            r = $urandom_range(0, 9);
            if (r <= 6) a = AW'($urandom_range(0, 63));
            else if (r == 7) a = AW'(16'h0040 + $urandom_range(0, 3));
            else if (r == 8) a = AW'($urandom_range(64, 255));
            else a = AW'($urandom);
            add(i, a, 1'($urandom), 3'($urandom_range(0, 9) < 8 ? $urandom_range(0, 2)
                                                                   : $urandom_range(3, 7)),
                $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
         end
         run_burst(12);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
